// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: memory freeze, taken-branch flush and load-use stall,
// with a memory-timeout error state and a saturating stall-cycle counter.
module hazard_scheduler (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_mem2reg,
    input  logic        ex_write_en,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        Stall,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        pipe_hold,
    output logic        err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, MEMWAIT, ERROR} state_t;

    state_t     state;
    logic [7:0] wait_cnt;

    logic rt_used, rs_hit, rt_hit;
    logic freeze, branch, load_use;

    // rt is a true source only for R-type, BEQ, BNE and SW
    always_comb begin
        rt_used = (id_opcode == 6'h00) || (id_opcode == 6'h04) ||
                  (id_opcode == 6'h05) || (id_opcode == 6'h2b);
        rs_hit  = (ex_rt == id_rs);
        rt_hit  = (ex_rt == id_rt) && rt_used;
    end

    always_comb begin
        freeze   = (state != ERROR) && mem_req && !mem_ready;
        branch   = (state == RUN) && !freeze && branch_taken;
        load_use = (state == RUN) && !freeze && !branch_taken &&
                   ex_mem2reg && ex_write_en && (ex_rt != 5'd0) &&
                   (rs_hit || rt_hit);
    end

    always_comb begin
        Stall      = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        pipe_hold  = 1'b0;
        err        = 1'b0;
        if (RST) begin
            Stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (state == ERROR) begin
            Stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            err        = 1'b1;
        end else if (freeze) begin
            Stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (branch) begin
            Stall      = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (load_use) begin
            Stall      = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            flush_idex = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (Stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            case (state)
                ERROR: state <= ERROR;
                default: begin
                    if (freeze) begin
                        // 256th consecutive freeze cycle trips the timeout
                        state    <= (wait_cnt == 8'hFF) ? ERROR : MEMWAIT;
                        wait_cnt <= wait_cnt + 8'd1;
                    end else begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end
                end
            endcase
        end
    end

endmodule
